mem_access_unit: RTL and testbench

//   Load/store stage directly downstream of EX. Takes one memory request per handshake, drives
//   the data-memory port (data_addr/data_out) with a req/ack handshake, returns load data to the

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage between EX and the data-memory port.
// Accepts one request per handshake and drives a req/ack memory handshake.
// Load data is returned on a one-cycle register-file write pulse.
// Misaligned requests are rejected without touching memory.
// Optional feature: define MAU_TIMEOUT_EN to abandon a request that waits
// TIMEOUT_CYCLES cycles without data_ack. Without the macro, the unit waits
// indefinitely and timeout_o is tied 0.
module mem_access_unit #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned REG_AW         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic              ex_is_store_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [REG_AW-1:0] ex_dest_i,
    output logic              stall_o,
    output logic              data_req_o,
    output logic              data_we_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_out_o,
    input  logic              data_ack_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              wb_valid_o,
    output logic [REG_AW-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o,
    output logic              timeout_o
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                is_store_q, is_store_d;
    logic [REG_AW-1:0]   dest_q, dest_d;
    // Writeback fields are separate from the request latch so they hold
    // their last value even after a new request has been accepted.
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic                misalign_q, misalign_d;

`ifdef MAU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
`else
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state and latch updates; all outputs come from registers only.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_store_d = is_store_q;
        dest_d     = dest_q;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        misalign_d = 1'b0;
`ifdef MAU_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (ex_valid_i) begin
                    if (ex_addr_i[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end else begin
                        addr_d     = ex_addr_i;
                        wdata_d    = ex_wdata_i;
                        is_store_d = ex_is_store_i;
                        dest_d     = ex_dest_i;
                        state_d    = StReq;
`ifdef MAU_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            StReq: begin
                // An ack in the limit cycle takes priority over the timeout.
                if (data_ack_i) begin
                    if (is_store_q) begin
                        state_d = StIdle;
                    end else begin
                        wb_data_d = data_in_i;
                        wb_addr_d = dest_q;
                        state_d   = StResp;
                    end
                end
`ifdef MAU_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched fields; reset abandons any outstanding request.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_store_q <= 1'b0;
            dest_q     <= '0;
            wb_data_q  <= '0;
            wb_addr_q  <= '0;
            misalign_q <= 1'b0;
`ifdef MAU_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_store_q <= is_store_d;
            dest_q     <= dest_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            misalign_q <= misalign_d;
`ifdef MAU_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign ex_ready_o  = (state_q == StIdle);
    assign stall_o     = (state_q != StIdle);
    assign data_req_o  = (state_q == StReq);
    assign data_we_o   = (state_q == StReq) & is_store_q;
    assign data_addr_o = addr_q;
    assign data_out_o  = wdata_q;
    assign wb_valid_o  = (state_q == StResp);
    assign wb_addr_o   = wb_addr_q;
    assign wb_data_o   = wb_data_q;
    assign misalign_o  = misalign_q;
`ifdef MAU_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against spec-level latency/data expectations.
module tb_mem_access_unit;

    localparam int TO_CYC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_ready, ex_is_store;
    logic [31:0] ex_addr, ex_wdata;
    logic [2:0]  ex_dest;
    logic        stall, data_req, data_we, data_ack;
    logic [31:0] data_addr, data_out, data_in;
    logic        wb_valid, misalign, timeout;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_wb_d = '0;
    logic [2:0]  last_wb_a = '0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W(32), .DATA_W(32), .REG_AW(3), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_is_store_i(ex_is_store),
        .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_dest_i(ex_dest),
        .stall_o(stall), .data_req_o(data_req), .data_we_o(data_we),
        .data_addr_o(data_addr), .data_out_o(data_out),
        .data_ack_i(data_ack), .data_in_i(data_in),
        .wb_valid_o(wb_valid), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .misalign_o(misalign), .timeout_o(timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned request and plays memory with an ack after `delay`
    // wait cycles; records what the DUT did, relative to the accept edge.
    task automatic do_txn(input bit st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] dest, input int delay, input logic [31:0] rdata,
                          output int req_cycles, output int wb_count, output int wb_lat,
                          output logic [31:0] wb_d, output logic [2:0] wb_a,
                          output bit stable_ok, output int ready_lat);
        req_cycles = 0; wb_count = 0; wb_lat = -1; wb_d = '0; wb_a = '0;
        stable_ok = 1'b1; ready_lat = -1;
        ex_valid = 1'b1; ex_is_store = st; ex_addr = addr; ex_wdata = wd; ex_dest = dest;
        tick();
        ex_valid = 1'b0; ex_addr = $urandom(); ex_wdata = $urandom();
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (data_req) begin
                req_cycles++;
                if (data_addr !== addr || data_we !== st || (st && data_out !== wd))
                    stable_ok = 1'b0;
            end
            if (wb_valid) begin
                wb_count++;
                if (wb_lat < 0) begin
                    wb_lat = cyc; wb_d = wb_data; wb_a = wb_addr;
                end
            end
            if (ex_ready) begin
                ready_lat = cyc;
                break;
            end
            if (data_req && req_cycles == delay + 1) begin
                data_ack = 1'b1; data_in = rdata;
            end else begin
                // Stray acks outside REQ must be ignored.
                data_ack = data_req ? 1'b0 : 1'($urandom_range(0, 1));
                data_in  = $urandom();
            end
            tick();
        end
        data_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ex_valid = 1'b0; ex_is_store = 1'b0; ex_addr = '0; ex_wdata = '0;
        ex_dest = '0; data_ack = 1'b0; data_in = '0;
        tick(); tick();
        checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL reset_ex_ready got %b exp 1", ex_ready); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL reset_data_req got %b exp 0", data_req); end
        checks++; if (data_we !== 1'b0) begin failures++; $display("FAIL reset_data_we got %b exp 0", data_we); end
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got %b exp 0", misalign); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b exp 0", timeout); end
        checks++; if (data_addr !== 32'h0 || wb_data !== 32'h0 || wb_addr !== 3'h0) begin
            failures++; $display("FAIL reset_latched got addr=%h wbd=%h wba=%0d exp 0", data_addr, wb_data, wb_addr);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        int rc, wc, wl, rl; logic [31:0] wd; logic [2:0] wa; bit ok;
        do_txn(1'b0, 32'h10, 32'h0, 3'd3, 0, 32'hDEADBEEF, rc, wc, wl, wd, wa, ok, rl);
        checks++; if (rc !== 1) begin failures++; $display("FAIL load_req_cycles got %0d exp 1", rc); end
        checks++; if (wc !== 1) begin failures++; $display("FAIL load_wb_count got %0d exp 1", wc); end
        checks++; if (wl !== 2) begin failures++; $display("FAIL load_wb_latency got %0d exp 2", wl); end
        checks++; if (wa !== 3'd3) begin failures++; $display("FAIL load_wb_addr got %0d exp 3", wa); end
        checks++; if (wd !== 32'hDEADBEEF) begin failures++; $display("FAIL load_wb_data got %h exp deadbeef", wd); end
        checks++; if (!ok) begin failures++; $display("FAIL load_req_fields got unstable exp stable"); end
        checks++; if (rl !== 3) begin failures++; $display("FAIL load_ready_latency got %0d exp 3", rl); end
        checks++; if (wb_data !== 32'hDEADBEEF || wb_addr !== 3'd3) begin
            failures++; $display("FAIL load_wb_hold got %h/%0d exp deadbeef/3", wb_data, wb_addr);
        end
        last_wb_d = 32'hDEADBEEF; last_wb_a = 3'd3;
    endtask

    task automatic test_store_delay();
        int rc, wc, wl, rl; logic [31:0] wd; logic [2:0] wa; bit ok;
        do_txn(1'b1, 32'h20, 32'h12345678, 3'd6, 3, 32'h0, rc, wc, wl, wd, wa, ok, rl);
        checks++; if (rc !== 4) begin failures++; $display("FAIL store_req_cycles got %0d exp 4", rc); end
        checks++; if (!ok) begin failures++; $display("FAIL store_req_fields got unstable exp stable"); end
        checks++; if (wc !== 0) begin failures++; $display("FAIL store_wb_count got %0d exp 0", wc); end
        checks++; if (rl !== 5) begin failures++; $display("FAIL store_ready_latency got %0d exp 5", rl); end
        checks++; if (wb_data !== last_wb_d || wb_addr !== last_wb_a) begin
            failures++; $display("FAIL store_wb_hold got %h/%0d exp %h/%0d", wb_data, wb_addr, last_wb_d, last_wb_a);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 32'h22 : {$urandom() & 32'hFFFF_FFFC} | 32'(i);
            ex_valid = 1'b1; ex_is_store = i[0]; ex_addr = a; ex_wdata = $urandom();
            ex_dest = 3'($urandom()); data_ack = 1'b1; data_in = $urandom();
            tick();
            ex_valid = 1'b0;
            checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_pulse addr=%h got %b exp 1", a, misalign); end
            checks++; if (data_req !== 1'b0) begin failures++; $display("FAIL misalign_no_req got %b exp 0", data_req); end
            checks++; if (ex_ready !== 1'b1) begin failures++; $display("FAIL misalign_ready got %b exp 1", ex_ready); end
            tick();
            checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle got %b exp 0", misalign); end
            checks++; if (data_req !== 1'b0 || wb_valid !== 1'b0) begin
                failures++; $display("FAIL misalign_quiet got req=%b wb=%b exp 0/0", data_req, wb_valid);
            end
            data_ack = 1'b0;
        end
    endtask

    task automatic test_busy_reset();
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_addr = 32'h40; ex_dest = 3'd5; ex_wdata = '0;
        tick();
        // A different request waits while the first is outstanding.
        ex_is_store = 1'b1; ex_addr = 32'h80; ex_wdata = 32'hA5A5_5A5A; ex_dest = 3'd1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ex_ready !== 1'b0 || stall !== 1'b1 || data_addr !== 32'h40) begin
                failures++; $display("FAIL busy_hold got ready=%b stall=%b addr=%h exp 0/1/00000040", ex_ready, stall, data_addr);
            end
            tick();
        end
        data_ack = 1'b1; data_in = 32'h0BAD_F00D;
        tick();
        data_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_addr !== 3'd5) begin
            failures++; $display("FAIL busy_first_wb got %b/%h/%0d exp 1/0badf00d/5", wb_valid, wb_data, wb_addr);
        end
        last_wb_d = 32'h0BAD_F00D; last_wb_a = 3'd5;
        tick();
        checks++; if (ex_ready !== 1'b1 || data_req !== 1'b0) begin
            failures++; $display("FAIL busy_idle got ready=%b req=%b exp 1/0", ex_ready, data_req);
        end
        tick();
        ex_valid = 1'b0;
        checks++; if (data_req !== 1'b1 || data_addr !== 32'h80 || data_we !== 1'b1 || data_out !== 32'hA5A5_5A5A) begin
            failures++; $display("FAIL busy_second_accept got req=%b addr=%h we=%b out=%h exp 1/00000080/1/a5a55a5a", data_req, data_addr, data_we, data_out);
        end
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (data_req !== 1'b0 || ex_ready !== 1'b1) begin
            failures++; $display("FAIL reset_async_drop got req=%b ready=%b exp 0/1", data_req, ex_ready);
        end
        data_ack = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b0 || data_req !== 1'b0 || stall !== 1'b0) begin
                failures++; $display("FAIL reset_no_wb got wb=%b req=%b stall=%b exp 0/0/0", wb_valid, data_req, stall);
            end
        end
        data_ack = 1'b0;
        last_wb_d = '0; last_wb_a = '0;
    endtask

    task automatic test_timeout();
        int req_cnt = 0, to_cnt = 0, to_at = -1;
        ex_valid = 1'b1; ex_is_store = 1'b1; ex_addr = 32'h100; ex_wdata = 32'h1; ex_dest = '0;
        data_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (data_req) req_cnt++;
            if (timeout) begin to_cnt++; to_at = cyc; end
            tick();
        end
`ifdef MAU_TIMEOUT_EN
        checks++; if (req_cnt !== TO_CYC) begin failures++; $display("FAIL timeout_req_cycles got %0d exp %0d", req_cnt, TO_CYC); end
        checks++; if (to_cnt !== 1 || to_at !== TO_CYC + 1) begin
            failures++; $display("FAIL timeout_pulse got count=%0d at=%0d exp 1 at %0d", to_cnt, to_at, TO_CYC + 1);
        end
        checks++; if (ex_ready !== 1'b1 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_idle got ready=%b wb=%b exp 1/0", ex_ready, wb_valid);
        end
`else
        checks++; if (req_cnt !== 30) begin failures++; $display("FAIL wait_req_cycles got %0d exp 30", req_cnt); end
        checks++; if (to_cnt !== 0) begin failures++; $display("FAIL wait_timeout got %0d pulses exp 0", to_cnt); end
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        checks++; if (ex_ready !== 1'b1 || data_req !== 1'b0) begin
            failures++; $display("FAIL wait_complete got ready=%b req=%b exp 1/0", ex_ready, data_req);
        end
`endif
    endtask

    task automatic test_random();
        int rc, wc, wl, rl, d; logic [31:0] wd, a, w, r; logic [2:0] wa, dst; bit ok, st;
        for (int n = 0; n < 24; n++) begin
            st = 1'($urandom_range(0, 1)); d = $urandom_range(0, TO_CYC - 1);
            a = $urandom() & 32'hFFFF_FFFC; w = $urandom(); r = $urandom(); dst = 3'($urandom());
            do_txn(st, a, w, dst, d, r, rc, wc, wl, wd, wa, ok, rl);
            if (!st) begin last_wb_d = r; last_wb_a = dst; end
            checks++; if (rc !== d + 1) begin failures++; $display("FAIL rand%0d_req_cycles got %0d exp %0d", n, rc, d + 1); end
            checks++; if (!ok) begin failures++; $display("FAIL rand%0d_req_fields got unstable exp stable", n); end
            checks++; if (wc !== (st ? 0 : 1)) begin failures++; $display("FAIL rand%0d_wb_count got %0d exp %0d", n, wc, st ? 0 : 1); end
            checks++; if (rl !== d + (st ? 2 : 3)) begin failures++; $display("FAIL rand%0d_ready_latency got %0d exp %0d", n, rl, d + (st ? 2 : 3)); end
            if (!st) begin
                checks++; if (wl !== d + 2 || wd !== r || wa !== dst) begin
                    failures++; $display("FAIL rand%0d_wb got lat=%0d %h/%0d exp lat=%0d %h/%0d", n, wl, wd, wa, d + 2, r, dst);
                end
            end
            checks++; if (wb_data !== last_wb_d || wb_addr !== last_wb_a) begin
                failures++; $display("FAIL rand%0d_wb_hold got %h/%0d exp %h/%0d", n, wb_data, wb_addr, last_wb_d, last_wb_a);
            end
            // Zero gap exercises back-to-back accept in the first IDLE cycle.
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delay();
        test_misalign();
        test_busy_reset();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
